// File: rtl/regfile_wr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_sched_if
// Purpose  : Request/response bundle between the writeback stage, the load
//            return path, the register file write port and the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wr_sched_if #(
  parameter int ADDR_SIZE  = 5,
  parameter int DATA_WIDTH = 32
);
  // Pipeline writeback requester
  logic                  wb_valid;
  logic [ADDR_SIZE-1:0]  wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_stall;
  // Load / long-op return requester
  logic                  ld_valid;
  logic [ADDR_SIZE-1:0]  ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;
  // Register file write port (WE3/WA3/WD3)
  logic                  rf_we;
  logic [ADDR_SIZE-1:0]  rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;
  logic                  init_busy;

  // Scheduler side
  modport slave (
    input  wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    output wb_stall, ld_ready, rf_we, rf_wa, rf_wd, init_busy
  );

  // Requester / register-file side
  modport master (
    output wb_valid, wb_addr, wb_data, ld_valid, ld_addr, ld_data,
    input  wb_stall, ld_ready, rf_we, rf_wa, rf_wd, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_sched
// Purpose  : Single write-port scheduler for the register file. Clears
//            registers 1..N-1 after reset, then arbitrates writeback (priority)
//            against the load return path with an anti-starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_sched #(
  parameter int                    ADDR_SIZE    = 5,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter int                    STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               rst,
  regfile_wr_sched_if.slave  bus
);

  localparam logic [0:0]           ST_INIT    = 1'b0;
  localparam logic [0:0]           ST_RUN     = 1'b1;
  localparam logic [3:0]           STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_SIZE-1:0] PTR_LAST   = {ADDR_SIZE{1'b1}};

  logic [0:0]            state_q,      state_d;
  logic [ADDR_SIZE-1:0]  init_ptr_q,   init_ptr_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  rf_we_q,      rf_we_d;
  logic [ADDR_SIZE-1:0]  rf_wa_q,      rf_wa_d;
  logic [DATA_WIDTH-1:0] rf_wd_q,      rf_wd_d;

  logic wb_stall_c;
  logic ld_ready_c;
  logic init_busy_c;
  logic wb_accept;
  logic ld_accept;

  // State register: sequencer state, clear pointer, starvation count, write port
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= ADDR_SIZE'(1);
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  // Handshake outputs: blocked during reset and INIT, otherwise arbitrate on starvation
  always_comb begin
    wb_stall_c  = 1'b1;
    ld_ready_c  = 1'b0;
    init_busy_c = 1'b1;
    if (rst && (state_q == ST_RUN)) begin
      init_busy_c = 1'b0;
      if (starve_cnt_q == STARVE_MAX) begin
        ld_ready_c = 1'b1;
        wb_stall_c = bus.ld_valid;
      end else begin
        wb_stall_c = 1'b0;
        ld_ready_c = !bus.wb_valid;
      end
    end
    wb_accept = bus.wb_valid && !wb_stall_c;
    ld_accept = bus.ld_valid && ld_ready_c;
  end

  // Next state: clear sequence in INIT, one accepted request per cycle in RUN
  always_comb begin
    state_d      = state_q;
    init_ptr_d   = init_ptr_q;
    starve_cnt_d = starve_cnt_q;
    rf_we_d      = 1'b0;
    rf_wa_d      = rf_wa_q;
    rf_wd_d      = rf_wd_q;
    case (state_q)
      ST_INIT: begin
        rf_we_d    = 1'b1;
        rf_wa_d    = init_ptr_q;
        rf_wd_d    = INIT_VALUE;
        init_ptr_d = init_ptr_q + ADDR_SIZE'(1);
        if (init_ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Address 0 completes the handshake but never reaches the file
        if (wb_accept) begin
          rf_we_d = |bus.wb_addr;
          if (|bus.wb_addr) begin
            rf_wa_d = bus.wb_addr;
            rf_wd_d = bus.wb_data;
          end
        end else if (ld_accept) begin
          rf_we_d = |bus.ld_addr;
          if (|bus.ld_addr) begin
            rf_wa_d = bus.ld_addr;
            rf_wd_d = bus.ld_data;
          end
        end
        if (ld_accept) begin
          starve_cnt_d = '0;
        end else if (bus.ld_valid && (starve_cnt_q != STARVE_MAX)) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.wb_stall  = wb_stall_c;
  assign bus.ld_ready  = ld_ready_c;
  assign bus.init_busy = init_busy_c;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_wa_q;
  assign bus.rf_wd     = rf_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_sched
// Purpose  : Scoreboard bench for regfile_wr_sched: directed scenarios plus
//            randomized traffic against a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_sched;

  localparam int          ADDR_SIZE    = 5;
  localparam int          DATA_WIDTH   = 32;
  localparam int          STARVE_LIMIT = 4;
  localparam int          NREG         = 1 << ADDR_SIZE;
  localparam logic [31:0] INIT_VALUE   = 32'h0;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  exp_t        sb_q[$];
  logic [31:0] rf_mirror [NREG];

  // Reference model state
  bit m_init;
  int m_ptr;
  int m_starve;
  bit prev_rst_low;
  bit dut_wb_acc;
  bit dut_ld_acc;

  regfile_wr_sched_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus ();

  regfile_wr_sched #(
    .ADDR_SIZE   (ADDR_SIZE),
    .DATA_WIDTH  (DATA_WIDTH),
    .INIT_VALUE  (INIT_VALUE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Register file as seen from the write port; address 0 is hardwired
  always @(posedge CLK) begin
    if (bus.rf_we === 1'b1 && bus.rf_wa != 5'd0) rf_mirror[bus.rf_wa] <= bus.rf_wd;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write
  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus.rf_we === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: actual wa=%0d wd=%h required no write (cycle %0d)",
                   bus.rf_wa, bus.rf_wd, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("rf_wa", bus.rf_wa, e.addr);
          chk("rf_wd", bus.rf_wd, e.data);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_write: actual rf_we=%b required write wa=%0d wd=%h (cycle %0d)",
                 bus.rf_we, sb_q[0].addr, sb_q[0].data, cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // One cycle: inputs already driven; check handshake against the model, predict writes
  task automatic tick();
    bit ld_wins;
    bit exp_wb_acc;
    bit exp_ld_acc;
    #1;
    dut_wb_acc = (bus.wb_valid === 1'b1) && (bus.wb_stall === 1'b0);
    dut_ld_acc = (bus.ld_valid === 1'b1) && (bus.ld_ready === 1'b1);
    if (prev_rst_low) begin
      chk("reset_rf_we", bus.rf_we, 1'b0);
      chk("reset_rf_wa", bus.rf_wa, 5'd0);
      chk("reset_rf_wd", bus.rf_wd, 32'd0);
    end
    if (!rst) begin
      chk("rst_init_busy", bus.init_busy, 1'b1);
      chk("rst_wb_stall", bus.wb_stall, 1'b1);
      chk("rst_ld_ready", bus.ld_ready, 1'b0);
      m_init   = 1'b1;
      m_ptr    = 1;
      m_starve = 0;
    end else if (m_init) begin
      chk("init_busy", bus.init_busy, 1'b1);
      chk("init_wb_stall", bus.wb_stall, 1'b1);
      chk("init_ld_ready", bus.ld_ready, 1'b0);
      sb_q.push_back('{cyc: cyc + 1, addr: 5'(m_ptr), data: INIT_VALUE});
      m_ptr++;
      if (m_ptr == NREG) m_init = 1'b0;
    end else begin
      // Load path wins whenever it asks once it has waited STARVE_LIMIT cycles;
      // otherwise writeback wins whenever it asks and load takes idle cycles.
      ld_wins    = (m_starve == STARVE_LIMIT);
      exp_ld_acc = bus.ld_valid && (ld_wins || !bus.wb_valid);
      exp_wb_acc = bus.wb_valid && !(ld_wins && bus.ld_valid);
      chk("run_init_busy", bus.init_busy, 1'b0);
      chk("wb_stall", bus.wb_stall, ld_wins && bus.ld_valid);
      chk("ld_ready", bus.ld_ready, ld_wins || !bus.wb_valid);
      if (exp_wb_acc && bus.wb_addr != 5'd0)
        sb_q.push_back('{cyc: cyc + 1, addr: bus.wb_addr, data: bus.wb_data});
      if (exp_ld_acc && bus.ld_addr != 5'd0)
        sb_q.push_back('{cyc: cyc + 1, addr: bus.ld_addr, data: bus.ld_data});
      if (exp_ld_acc)                                   m_starve = 0;
      else if (bus.ld_valid && m_starve < STARVE_LIMIT) m_starve++;
    end
    prev_rst_low = !rst;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst          = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    m_init = 1'b1; m_ptr = 1; m_starve = 0;
    prev_rst_low = 1'b1;
    @(posedge CLK);
    #1;
    mon_en = 1'b1;

    // Reset held for two edges, then the clear sequence with no requests
    tick();
    rst = 1'b1;
    repeat (31) tick();
    repeat (3) tick();

    // Uncontended writeback
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick();
    chk("wb_accept_5", dut_wb_acc, 1'b1);
    bus.wb_valid = 1'b0;
    tick();
    tick();
    chk("rf_read_5", rf_mirror[5], 32'hDEADBEEF);

    // Continuous writeback against a held load: load wins after STARVE_LIMIT blocks
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd3;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h1234;
    n = 0;
    while (n < 12) begin
      bus.wb_data = $urandom;
      tick();
      n++;
      if (dut_ld_acc) break;
    end
    chk("starve_wait", n, STARVE_LIMIT + 1);
    bus.ld_valid = 1'b0;
    tick();
    chk("wb_resume", dut_wb_acc, 1'b1);
    bus.wb_valid = 1'b0;
    tick();

    // Load to address 0: accepted, never written
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd0; bus.ld_data = 32'hFFFFFFFF;
    tick();
    chk("ld_accept_0", dut_ld_acc, 1'b1);
    bus.ld_valid = 1'b0;
    tick();
    tick();

    // Reset during the clear sequence, with both requesters asserted throughout
    bus.wb_valid = 1'b1; bus.wb_addr = 5'd9;  bus.wb_data = 32'hA5A5_0009;
    bus.ld_valid = 1'b1; bus.ld_addr = 5'd12; bus.ld_data = 32'h5A5A_000C;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (m_ptr <= 10 && n < 40) begin
      tick();
      n++;
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("init_len_after_abort", n, 31);
    n = 0;
    while (n < 12) begin
      tick();
      n++;
      if (n == 1) chk("first_run_wb", dut_wb_acc, 1'b1);
      if (dut_wb_acc) bus.wb_data = $urandom;
      if (dut_ld_acc) break;
    end
    chk("init_then_ld_wait", n, STARVE_LIMIT + 1);
    bus.wb_valid = 1'b0;
    bus.ld_valid = 1'b0;
    tick();

    // Randomized traffic; requesters hold until accepted, occasional resets
    for (int i = 0; i < 500; i++) begin
      if (!(bus.wb_valid && !dut_wb_acc)) begin
        bus.wb_valid = ($urandom_range(0, 1) == 1);
        bus.wb_addr  = 5'($urandom_range(0, NREG - 1));
        bus.wb_data  = $urandom;
      end
      if (!(bus.ld_valid && !dut_ld_acc)) begin
        bus.ld_valid = ($urandom_range(0, 2) != 0);
        bus.ld_addr  = 5'($urandom_range(0, NREG - 1));
        bus.ld_data  = $urandom;
      end
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end

    rst = 1'b1;
    bus.wb_valid = 1'b0;
    bus.ld_valid = 1'b0;
    while (m_init) tick();
    repeat (3) tick();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_sched.md
Name: regfile_wr_sched

Overview:
- Single-write-port scheduler in front of the 32x32 register file.
- After reset it sequences a clear of registers 1..31, replacing file-based preload.
- In RUN it arbitrates the one write port between two requesters:
  - the pipeline writeback stage, which has priority;
  - a multi-cycle load/long-op return path with a valid/ready handshake.
- An anti-starvation counter guarantees forward progress for the secondary path.
- Write outputs are registered and drive the register file's WE3/WA3/WD3 directly.

Parameters:
ADDR_SIZE, 5, register address width; register count = 2**ADDR_SIZE
DATA_WIDTH, 32, register data width
INIT_VALUE, 0, value written to every register 1..2**ADDR_SIZE-1 during INIT
STARVE_LIMIT, 4, consecutive blocked cycles of ld_valid before the load path takes priority (range 1..15)

Ports:
CLK  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
wb_valid  input  1  pipeline writeback request
wb_addr  input  ADDR_SIZE  writeback destination
wb_data  input  DATA_WIDTH  writeback data
wb_stall  output  1  writeback not accepted this cycle; pipeline holds wb_* stable
ld_valid  input  1  load-return request
ld_addr  input  ADDR_SIZE  load destination
ld_data  input  DATA_WIDTH  load data
ld_ready  output  1  load request accepted this cycle when ld_valid=1
rf_we  output  1  register file write enable (to WE3)
rf_wa  output  ADDR_SIZE  register file write address (to WA3)
rf_wd  output  DATA_WIDTH  register file write data (to WD3)
init_busy  output  1  INIT sequence in progress

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=INIT, init_ptr=1, starve_cnt=0;
  - rf_we=0, rf_wa=0, rf_wd=0;
  - init_busy=1, wb_stall=1, ld_ready=0.
  - Reset asserted at any point, including mid-INIT or mid-handshake, aborts everything. Any request offered in that cycle is not accepted.
- States: INIT, RUN. No other states.
- INIT:
  - Each cycle registers rf_we=1, rf_wa=init_ptr, rf_wd=INIT_VALUE, then increments init_ptr.
  - After the cycle that writes address 2**ADDR_SIZE-1, the next state is RUN.
  - Address 0 is never written.
  - 31 write cycles for ADDR_SIZE=5.
  - init_busy=1 and wb_stall=1 for the whole state; ld_ready=0; requests are ignored.
- RUN:
  - init_busy=0.
  - Arbitration is combinational from the current inputs and starve_cnt:
    - starve_cnt < STARVE_LIMIT: wb has priority. wb_stall=0; ld_ready = !wb_valid.
    - starve_cnt == STARVE_LIMIT: ld has priority. ld_ready=1; wb_stall = ld_valid.
  - An accepted request in cycle N produces rf_we=1, rf_wa/rf_wd = the request's addr/data in cycle N+1 (one-cycle latency). Data lands in the register file at the end of N+1.
  - No acceptance in cycle N gives rf_we=0 in N+1. rf_wa/rf_wd hold their previous values.
  - Destination address 0: the handshake completes normally (wb_stall=0 or ld_ready=1), but rf_we=0 in N+1.
  - At most one write per cycle; a cycle never accepts both requesters.
- starve_cnt (RUN only):
  - Increments when ld_valid=1 and ld_ready=0.
  - Clears to 0 on an ld handshake (ld_valid & ld_ready).
  - Holds when ld_valid=0.
  - Saturates at STARVE_LIMIT.
- wb_stall with wb_valid=0 has no effect on the pipeline.
- Requesters must hold valid/addr/data stable until accepted; the block does not buffer.

Test Plan:
- Reset release:
  - Stimulus: rst=0 for 2 cycles, then 1, no requests.
  - Required: rf_we=1 for exactly 31 consecutive cycles, rf_wa=1..31 in order, rf_wd=0.
  - Required: init_busy falls the cycle after the write to address 31; rf_we=0 thereafter.
- Priority, no contention:
  - Stimulus in RUN: wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF in cycle N.
  - Required: wb_stall=0 in N; rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in N+1. The regfile read of RA1=5 returns 0xDEADBEEF in N+2.
- Contention with starvation (STARVE_LIMIT=4):
  - Stimulus: wb_valid=1 every cycle (addr 3); ld_valid=1, ld_addr=7, ld_data=0x1234 held.
  - Required: ld_ready=0 for 4 cycles, then ld_ready=1 and wb_stall=1 in the 5th cycle.
  - Required: next cycle rf_wa=7, rf_wd=0x1234; starve_cnt returns to 0 and wb resumes.
- Address zero:
  - Stimulus: ld_valid=1, ld_addr=0, ld_data=0xFFFFFFFF with no wb.
  - Required: ld_ready=1, rf_we=0 next cycle; register 0 reads 0.
- Reset mid-INIT:
  - Stimulus: rst=0 for one cycle after the write to address 10.
  - Required: all outputs return to reset values. INIT restarts at address 1 and performs a full 31 writes.
- Requests during INIT:
  - Stimulus: wb_valid=1 and ld_valid=1 asserted throughout INIT.
  - Required: wb_stall=1 and ld_ready=0 until RUN. The first RUN cycle accepts wb; ld is accepted after STARVE_LIMIT blocked cycles.
